// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: scans a 4x4 keypad, debounces, encodes one key as {col,row} on a valid/ack handshake
// Ports: clk, rst_n (async active-low), row_i[3:0] row sense, col_o[3:0] one-hot column drive,
//        key_code[3:0] reported key, key_valid report pending, key_ack consumer accept, overrun dropped-press pulse
module keypad_scan_encoder #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overrun
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {IDLE, DEB, HELD} state_t;
  state_t state, state_n;
  logic [DW-1:0] div;
  logic [1:0] col;
  logic [15:0] snap;
  logic frame_done, none, accept;
  logic [3:0] cand, stored, stored_n;
  logic [CW-1:0] cnt, cnt_n, run;
  wire div_last = div == DW'(SCAN_DIV - 1);
  assign col_o = 4'b0001 << col;
  assign none = snap == 16'h0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      col        <= '0;
      snap       <= '0;
      frame_done <= 1'b0;
    end else begin
      div        <= div_last ? '0 : div + 1'b1;
      frame_done <= div_last && col == 2'd3;
      if (div_last) begin
        col                  <= col + 1'b1;
        snap[{col, 2'b00} +: 4] <= row_i;
      end
    end
  end
  // Lowest set snapshot bit wins, so simultaneous keys resolve to the smallest code.
  always_comb begin
    cand = '0;
    for (int i = 15; i >= 0; i--)
      if (snap[i]) cand = 4'(i);
  end
  // A new or changed candidate restarts the match run at one frame.
  assign run = (state == DEB && cand == stored) ? cnt + 1'b1 : CW'(1);
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stored_n = stored;
    accept   = 1'b0;
    if (frame_done) begin
      case (state)
        IDLE, DEB: begin
          if (none) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            stored_n = cand;
            accept   = run >= CW'(DEBOUNCE);
            state_n  = accept ? HELD : DEB;
            cnt_n    = accept ? '0 : run;
          end
        end
        HELD: begin
          cnt_n   = none ? cnt + 1'b1 : '0;
          state_n = (none && cnt_n == CW'(DEBOUNCE)) ? IDLE : HELD;
          cnt_n   = (state_n == IDLE) ? '0 : cnt_n;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      stored    <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      stored    <= stored_n;
      key_valid <= (accept && !key_valid) ? 1'b1 : key_valid && !key_ack;
      overrun   <= accept && key_valid;
      if (accept && !key_valid) key_code <= stored_n;
    end
  end
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb_keypad_scan_encoder: directed table-driven bench for keypad_scan_encoder (SCAN_DIV=2, DEBOUNCE=2)
module tb_keypad_scan_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] row_i, col_o, key_code;
  logic key_valid, key_ack, overrun;
  logic [15:0] keys;
  int n_chk = 0;
  int n_fail = 0;
  int ovr_cnt = 0;
  typedef struct {
    logic [15:0] keys;
    logic        ack;
    int          cyc;
    logic        valid;
    logic [3:0]  code;
    int          ovr;
  } vec_t;
  vec_t vec [19];
  keypad_scan_encoder #(.SCAN_DIV(2), .DEBOUNCE(2)) dut (
    .clk(clk), .rst_n(rst_n), .row_i(row_i), .col_o(col_o),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always_comb
    row_i = col_o == 4'b0001 ? keys[3:0] :
            col_o == 4'b0010 ? keys[7:4] :
            col_o == 4'b0100 ? keys[11:8] :
            col_o == 4'b1000 ? keys[15:12] : 4'h0;
  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    keys = '0;
    key_ack = 1'b0;
    vec[0]  = '{16'h0040, 1'b0, 16, 1'b0, 4'd0, 0};
    vec[1]  = '{16'h0040, 1'b0,  8, 1'b1, 4'd6, 0};
    vec[2]  = '{16'h0040, 1'b0, 16, 1'b1, 4'd6, 0};
    vec[3]  = '{16'h0040, 1'b1,  1, 1'b0, 4'd6, 0};
    vec[4]  = '{16'h0040, 1'b0,  7, 1'b0, 4'd6, 0};
    vec[5]  = '{16'h0040, 1'b0, 24, 1'b0, 4'd6, 0};
    vec[6]  = '{16'h0000, 1'b0, 24, 1'b0, 4'd6, 0};
    vec[7]  = '{16'h0208, 1'b0, 24, 1'b1, 4'd3, 0};
    vec[8]  = '{16'h0208, 1'b1,  1, 1'b0, 4'd3, 0};
    vec[9]  = '{16'h0208, 1'b0,  7, 1'b0, 4'd3, 0};
    vec[10] = '{16'h0000, 1'b0, 24, 1'b0, 4'd3, 0};
    vec[11] = '{16'h0020, 1'b0,  8, 1'b0, 4'd3, 0};
    vec[12] = '{16'h0000, 1'b0, 24, 1'b0, 4'd3, 0};
    vec[13] = '{16'h0040, 1'b0, 24, 1'b1, 4'd6, 0};
    vec[14] = '{16'h0000, 1'b0, 16, 1'b1, 4'd6, 0};
    vec[15] = '{16'h1000, 1'b0, 24, 1'b1, 4'd6, 1};
    vec[16] = '{16'h1000, 1'b1,  1, 1'b0, 4'd6, 1};
    vec[17] = '{16'h0000, 1'b0,  7, 1'b0, 4'd6, 1};
    vec[18] = '{16'h0000, 1'b0, 16, 1'b0, 4'd6, 1};
    #2 rst_n = 1'b0;
    #1;
    chk("rst_col", 32'(col_o), 32'h1);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic [3:0] exp_col;
      @(posedge clk) #1;
      exp_col = 4'b0001 << ((k / 2) % 4);
      chk($sformatf("scan_col_%0d", k), 32'(col_o), 32'(exp_col));
      chk($sformatf("scan_valid_%0d", k), 32'(key_valid), 32'h0);
    end
    for (int i = 0; i < 19; i++) begin
      keys = vec[i].keys;
      key_ack = vec[i].ack;
      repeat (vec[i].cyc) @(posedge clk);
      #1;
      key_ack = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(key_valid), 32'(vec[i].valid));
      chk($sformatf("vec%0d_code", i), 32'(key_code), 32'(vec[i].code));
      chk($sformatf("vec%0d_overrun", i), 32'(ovr_cnt), 32'(vec[i].ovr));
    end
    keys = 16'h0040;
    repeat (12) @(posedge clk);
    #1;
    chk("deb_valid", 32'(key_valid), 32'h0);
    chk("deb_col", 32'(col_o), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("arst_col", 32'(col_o), 32'h1);
    chk("arst_code", 32'(key_code), 32'h0);
    chk("arst_valid", 32'(key_valid), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("fresh_wait_valid", 32'(key_valid), 32'h0);
    @(posedge clk) #1;
    chk("fresh_valid", 32'(key_valid), 32'h1);
    chk("fresh_code", 32'(key_code), 32'h6);
    chk("fresh_overrun", 32'(ovr_cnt), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
